load_balancer: RTL and testbench

Request load balancer between the HTTP front end and four reconfigurable compute regions. It buffers per-request metadata from an AXI4-Stream sink in an internal FIFO and dispatches each entry to the least-loaded available region, using 16-bit per-region load statistics. Dispatch decisions are published on `lb_ctrl`. When the balancer is stalled with every region saturated, it requests partial reconfiguration on `pr_ctrl`.

---
 rtl/lb_pkg.sv | 19 +
 rtl/lb_sync_fifo.sv | 43 ++++
 rtl/load_balancer.sv | 136 +++++++++++++
 tb/tb_load_balancer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// rtl/lb_pkg.sv - shared constants, field positions and types for the load balancer
package lb_pkg;

    localparam int NUM_REGIONS = 4;
    localparam int STAT_W      = 16;
    localparam int CTRL_W      = 32;

    localparam logic [STAT_W-1:0] PR_THRESHOLD   = 16'd16;
    localparam logic [STAT_W-1:0] STAT_SATURATED = 16'hFFFF;

    localparam int LB_STROBE_BIT  = 31;
    localparam int LB_REGION_LSB  = 24;
    localparam int PR_REQ_BIT     = 31;
    localparam int PR_REGION_LSB  = 24;
    localparam int PR_STALL_LSB   = 0;

    typedef logic [1:0] region_idx_t;

endpackage

// File: rtl/lb_sync_fifo.sv
// rtl/lb_sync_fifo.sv - synchronous FIFO holding request metadata entries
module lb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_in,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             is_full,
    output logic             is_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] data [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign is_empty = (r_wr_ptr == r_rd_ptr);
    assign is_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign head     = data[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push && !is_full) begin
                data[r_wr_ptr[AW-1:0]] <= data_in;
                r_wr_ptr               <= r_wr_ptr + 1'b1;
            end
            if (pop && !is_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/load_balancer.sv
// rtl/load_balancer.sv - least-loaded region dispatcher; optional PR requests under LB_PR_EN
module load_balancer
    import lb_pkg::*;
#(
    parameter int HTTP_DATA_WIDTH = 8,
    parameter int QDEPTH          = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       meta_snk_tvalid,
    output logic                       meta_snk_tready,
    input  logic [HTTP_DATA_WIDTH-1:0] meta_snk_tdata,
    input  logic                       meta_snk_tlast,
    input  logic                       hdr_snk_tvalid,
    output logic                       hdr_snk_tready,
    input  logic [HTTP_DATA_WIDTH-1:0] hdr_snk_tdata,
    input  logic                       hdr_snk_tlast,
    input  logic                       bdy_snk_tvalid,
    output logic                       bdy_snk_tready,
    input  logic [HTTP_DATA_WIDTH-1:0] bdy_snk_tdata,
    input  logic                       bdy_snk_tlast,
    input  logic [63:0]                region_stats_in,
    output logic [CTRL_W-1:0]          lb_ctrl,
    output logic [CTRL_W-1:0]          pr_ctrl
);

    logic [HTTP_DATA_WIDTH-1:0] w_head;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_push;
    logic                       w_dispatch;
    logic                       w_any_avail;
    logic [STAT_W-1:0]          w_load [NUM_REGIONS];
    logic [STAT_W-1:0]          w_min01;
    logic [STAT_W-1:0]          w_min23;
    logic [STAT_W-1:0]          w_min;
    region_idx_t                w_sel01;
    region_idx_t                w_sel23;
    region_idx_t                w_sel;
    logic [CTRL_W-1:0]          r_lb_ctrl;
    logic                       w_unused;

    assign w_unused = ^{meta_snk_tlast, hdr_snk_tvalid, hdr_snk_tdata, hdr_snk_tlast,
                        bdy_snk_tvalid, bdy_snk_tdata, bdy_snk_tlast};

    assign meta_snk_tready = aresetn && !w_full;
    assign hdr_snk_tready  = 1'b1;
    assign bdy_snk_tready  = 1'b1;
    assign w_push          = meta_snk_tvalid && meta_snk_tready;

    lb_sync_fifo #(
        .WIDTH (HTTP_DATA_WIDTH),
        .DEPTH (QDEPTH)
    ) meta_queue (
        .clk      (aclk),
        .resetn   (aresetn),
        .data_in  (meta_snk_tdata),
        .push     (w_push),
        .pop      (w_dispatch),
        .head     (w_head),
        .is_full  (w_full),
        .is_empty (w_empty)
    );

    always_comb begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
            w_load[i] = region_stats_in[STAT_W*i +: STAT_W];
        end
    end

    // Two-level min tree; strict '<' keeps the lower index on ties at each level.
    assign w_sel01 = (w_load[1] < w_load[0]) ? 2'd1 : 2'd0;
    assign w_min01 = (w_load[1] < w_load[0]) ? w_load[1] : w_load[0];
    assign w_sel23 = (w_load[3] < w_load[2]) ? 2'd3 : 2'd2;
    assign w_min23 = (w_load[3] < w_load[2]) ? w_load[3] : w_load[2];
    assign w_sel   = (w_min23 < w_min01) ? w_sel23 : w_sel01;
    assign w_min   = (w_min23 < w_min01) ? w_min23 : w_min01;

    assign w_any_avail = (w_min != STAT_SATURATED);
    assign w_dispatch  = !w_empty && w_any_avail;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_lb_ctrl <= '0;
        end else begin
            r_lb_ctrl[LB_STROBE_BIT] <= w_dispatch;
            if (w_dispatch) begin
                r_lb_ctrl[LB_REGION_LSB +: 2]     <= w_sel;
                r_lb_ctrl[HTTP_DATA_WIDTH-1:0]    <= w_head;
            end
        end
    end

    assign lb_ctrl = r_lb_ctrl;

`ifdef LB_PR_EN
    logic [STAT_W-1:0] r_stall_cnt;
    logic              r_pr_req;
    region_idx_t       r_pr_ptr;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_stall_cnt <= '0;
            r_pr_req    <= 1'b0;
            r_pr_ptr    <= '0;
        end else begin
            if (w_full && !w_any_avail) begin
                if (r_stall_cnt != STAT_SATURATED) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end else begin
                r_stall_cnt <= '0;
            end
            // Dropping the request hands the next one to the following region.
            if (w_any_avail) begin
                if (r_pr_req) begin
                    r_pr_req <= 1'b0;
                    r_pr_ptr <= r_pr_ptr + 2'd1;
                end
            end else if (r_stall_cnt >= PR_THRESHOLD) begin
                r_pr_req <= 1'b1;
            end
        end
    end

    always_comb begin
        pr_ctrl                             = '0;
        pr_ctrl[PR_REQ_BIT]                 = r_pr_req;
        pr_ctrl[PR_REGION_LSB +: 2]         = r_pr_ptr;
        pr_ctrl[PR_STALL_LSB +: STAT_W]     = r_stall_cnt;
    end
`else
    assign pr_ctrl = '0;
`endif

endmodule

// File: tb/tb_load_balancer.sv
// tb/tb_load_balancer.sv - randomized and directed self-checking bench for load_balancer
module tb_load_balancer;

    localparam int W      = 8;
    localparam int QDEPTH = 4;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         m_tvalid, m_tready, m_tlast;
    logic [W-1:0] m_tdata;
    logic         h_tvalid, h_tready, h_tlast;
    logic [W-1:0] h_tdata;
    logic         b_tvalid, b_tready, b_tlast;
    logic [W-1:0] b_tdata;
    logic [63:0]  stats;
    logic [31:0]  lb_ctrl, pr_ctrl;

    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] mq [$];
    logic [31:0]  exp_lb;
    logic [31:0]  exp_pr;
    int           exp_stall, exp_ptr;
    bit           exp_req;

    always #5 aclk = ~aclk;

    load_balancer #(.HTTP_DATA_WIDTH(W), .QDEPTH(QDEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .meta_snk_tvalid(m_tvalid), .meta_snk_tready(m_tready),
        .meta_snk_tdata(m_tdata), .meta_snk_tlast(m_tlast),
        .hdr_snk_tvalid(h_tvalid), .hdr_snk_tready(h_tready),
        .hdr_snk_tdata(h_tdata), .hdr_snk_tlast(h_tlast),
        .bdy_snk_tvalid(b_tvalid), .bdy_snk_tready(b_tready),
        .bdy_snk_tdata(b_tdata), .bdy_snk_tlast(b_tlast),
        .region_stats_in(stats), .lb_ctrl(lb_ctrl), .pr_ctrl(pr_ctrl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_lb    = '0;
        exp_stall = 0;
        exp_req   = 1'b0;
        exp_ptr   = 0;
    endtask

    // One clock: predict from the rules, advance the model, compare after the edge.
    task automatic cycle();
        int           sel;
        logic [15:0]  mn, ld;
        logic [W-1:0] din;
        bit           disp, acc, full, allsat;
        int           old_stall;
        chk("meta_tready", m_tready, mq.size() < QDEPTH);
        chk("hdr_bdy_tready", {h_tready, b_tready}, 2'b11);
        chk("fifo_empty", dut.meta_queue.is_empty, mq.size() == 0);
        mn  = 16'hFFFF;
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            ld = stats[16*i +: 16];
            if (ld < mn) begin
                mn  = ld;
                sel = i;
            end
        end
        allsat = (mn == 16'hFFFF);
        full   = (mq.size() == QDEPTH);
        disp   = (mq.size() > 0) && !allsat;
        acc    = m_tvalid && !full;
        din    = m_tdata;
        @(posedge aclk);
        #1;
        exp_lb[31] = 1'b0;
        if (disp) exp_lb = {1'b1, 5'b0, sel[1:0], 16'b0, mq.pop_front()};
        if (acc) mq.push_back(din);
`ifdef LB_PR_EN
        old_stall = exp_stall;
        if (full && allsat) begin
            if (exp_stall < 65535) exp_stall++;
        end else begin
            exp_stall = 0;
        end
        if (!allsat) begin
            if (exp_req) begin
                exp_req = 1'b0;
                exp_ptr = (exp_ptr + 1) % 4;
            end
        end else if (old_stall >= 16) begin
            exp_req = 1'b1;
        end
        exp_pr = {exp_req, 5'b0, exp_ptr[1:0], 8'b0, exp_stall[15:0]};
`else
        old_stall = 0;
        exp_pr = '0;
`endif
        chk("lb_ctrl", lb_ctrl, exp_lb);
        chk("pr_ctrl", pr_ctrl, exp_pr + 32'(old_stall * 0));
        @(negedge aclk);
    endtask

    task automatic do_reset(input int n);
        aresetn = 1'b0;
        #1;
        chk("tready_in_reset", m_tready, 1'b0);
        repeat (n) @(posedge aclk);
        #1;
        chk("reset_lb_ctrl", lb_ctrl, 32'h0);
        chk("reset_pr_ctrl", pr_ctrl, 32'h0);
        chk("reset_empty", dut.meta_queue.is_empty, 1'b1);
        model_clear();
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("tready_after_reset", m_tready, 1'b1);
    endtask

    initial begin
        logic [7:0] fill_vals [3];
        aresetn  = 1'b0;
        m_tvalid = 1'b0; m_tdata = '0; m_tlast = 1'b0;
        h_tvalid = 1'b1; h_tdata = 8'h11; h_tlast = 1'b0;
        b_tvalid = 1'b1; b_tdata = 8'h22; b_tlast = 1'b1;
        stats    = {64{1'b1}};
        model_clear();
        @(negedge aclk);
        do_reset(3);

        // Saturated regions hold the entry in the queue.
        m_tvalid = 1'b1; m_tdata = 8'hAA; m_tlast = 1'b1;
        cycle();
        m_tvalid = 1'b0;
        repeat (3) cycle();
        chk("hold_lb_ctrl", lb_ctrl, 32'h0);
        chk("hold_not_empty", dut.meta_queue.is_empty, 1'b0);

        fill_vals = '{8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 3; i++) begin
            m_tvalid = 1'b1; m_tdata = fill_vals[i];
            cycle();
        end
        m_tdata = 8'hEE;
        repeat (3) cycle();
        chk("full_tready", m_tready, 1'b0);

        stats = 64'h0123_4567_89AB_CDEF;
        cycle();
        chk("minload_record", lb_ctrl, 32'h8300_00AA);
        stats = {64{1'b1}};
        cycle();
        chk("strobe_one_cycle", lb_ctrl[31], 1'b0);
        m_tvalid = 1'b0;

        stats = 64'h0005_0005_FFFF_0009;
        cycle();
        chk("tiebreak_region", lb_ctrl[25:24], 2'd2);
        chk("tiebreak_data", lb_ctrl[7:0], 8'hBB);
        repeat (4) cycle();

        stats = 64'h0;
        m_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            m_tdata = 8'($urandom);
            cycle();
        end
        m_tvalid = 1'b0;
        cycle();

        stats = {64{1'b1}};
        m_tvalid = 1'b1;
        repeat (24) cycle();
`ifdef LB_PR_EN
        chk("pr_request", pr_ctrl[31], 1'b1);
        chk("pr_target", pr_ctrl[25:24], 2'd0);
        stats[47:32] = 16'h0000;
        cycle();
        chk("pr_cleared", pr_ctrl[31], 1'b0);
        chk("pr_pointer", pr_ctrl[25:24], 2'd1);
`endif

        for (int ph = 0; ph < 10; ph++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int c = 0; c < 40; c++) begin
                m_tvalid = ($urandom_range(0, 3) != 0);
                m_tdata  = 8'($urandom);
                for (int r = 0; r < 4; r++) begin
                    if (mode == 0 || $urandom_range(0, 2) == 0)
                        stats[16*r +: 16] = 16'hFFFF;
                    else if (mode == 1)
                        stats[16*r +: 16] = 16'($urandom_range(0, 3));
                    else
                        stats[16*r +: 16] = 16'($urandom_range(0, 16'hFFFE));
                end
                cycle();
            end
        end

        stats = {64{1'b1}};
        m_tvalid = 1'b1;
        repeat (3) cycle();
        do_reset(2);
        m_tvalid = 1'b1; m_tdata = 8'h5A; stats = 64'h0;
        cycle();
        m_tvalid = 1'b0;
        cycle();
        chk("post_reset_dispatch", lb_ctrl, 32'h8000_005A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
